// File: rtl/sisc_seq.sv
// Multi-cycle instruction sequencer for the SISC core.
// Walks RESET/FETCH/DECODE/EXEC/MEM/WB/HALT and drives registered control strobes.
module sisc_seq #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic [3:0] mm,
  input  logic [3:0] stat,
  input  logic       mem_ready,
  output logic       pc_rst,
  output logic       pc_write,
  output logic       pc_sel,
  output logic       ir_load,
  output logic       rf_we,
  output logic       wb_sel,
  output logic       stat_en,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       halted,
  output logic       err
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ALU = 4'h1;
  localparam logic [3:0] OP_BRR = 4'h2;
  localparam logic [3:0] OP_BRA = 4'h4;
  localparam logic [3:0] OP_LOD = 4'h8;
  localparam logic [3:0] OP_STR = 4'h9;

  state_t     state, state_nx;
  logic [3:0] op_q, op_nx, mm_q, mm_nx;
  logic [7:0] wait_cnt, wait_nx;
  logic       err_nx, taken;
  logic       pc_rst_nx, pc_write_nx, pc_sel_nx, ir_load_nx, rf_we_nx, wb_sel_nx;
  logic       stat_en_nx, mem_rd_nx, mem_wr_nx, halted_nx;

  // Next-state logic, then outputs decoded from the state being entered so they
  // can be registered and line up with that state.
  always_comb begin
    state_nx    = state;
    op_nx       = op_q;
    mm_nx       = mm_q;
    wait_nx     = wait_cnt;
    err_nx      = err;
    pc_rst_nx   = 1'b0;
    pc_write_nx = 1'b0;
    pc_sel_nx   = 1'b0;
    ir_load_nx  = 1'b0;
    rf_we_nx    = 1'b0;
    wb_sel_nx   = 1'b0;
    stat_en_nx  = 1'b0;
    mem_rd_nx   = 1'b0;
    mem_wr_nx   = 1'b0;
    halted_nx   = 1'b0;

    case (state)
      S_RESET:  state_nx = S_FETCH;
      S_FETCH:  state_nx = S_DECODE;
      S_DECODE: begin
        op_nx    = opcode;
        mm_nx    = mm;
        state_nx = S_EXEC;
      end
      S_EXEC: begin
        case (op_q)
          OP_NOP:         state_nx = (mm_q == 4'hF) ? S_HALT : S_FETCH;
          OP_ALU:         state_nx = S_WB;
          OP_BRR, OP_BRA: state_nx = S_FETCH;
          OP_LOD, OP_STR: begin
            state_nx = S_MEM;
            wait_nx  = 8'd1;
          end
          default: begin
            err_nx   = 1'b1;
            state_nx = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          state_nx = (op_q == OP_LOD) ? S_WB : S_FETCH;
        end else if (wait_cnt == 8'(WAIT_MAX)) begin
          err_nx   = 1'b1;
          state_nx = S_HALT;
        end else begin
          wait_nx  = wait_cnt + 8'd1;
        end
      end
      S_WB:    state_nx = S_FETCH;
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_RESET;
    endcase

    // Branch condition uses the opcode/mm/stat present while leaving DECODE.
    taken = (mm_nx == 4'h0) || ((mm_nx & stat) != 4'h0);

    case (state_nx)
      S_RESET: pc_rst_nx = 1'b1;
      S_FETCH: begin
        ir_load_nx  = 1'b1;
        pc_write_nx = 1'b1;
      end
      S_EXEC: begin
        if (op_nx == OP_ALU) begin
          stat_en_nx = 1'b1;
        end else if ((op_nx == OP_BRR || op_nx == OP_BRA) && taken) begin
          pc_write_nx = 1'b1;
          pc_sel_nx   = 1'b1;
        end else begin
          stat_en_nx = 1'b0;
        end
      end
      S_MEM: begin
        mem_rd_nx = (op_nx == OP_LOD);
        mem_wr_nx = (op_nx == OP_STR);
      end
      S_WB: begin
        rf_we_nx  = 1'b1;
        wb_sel_nx = (op_nx == OP_LOD);
      end
      S_HALT:  halted_nx = 1'b1;
      default: pc_rst_nx = 1'b0;
    endcase
  end

  // State and registered outputs; reset aborts any instruction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_RESET;
      op_q     <= 4'h0;
      mm_q     <= 4'h0;
      wait_cnt <= 8'd0;
      err      <= 1'b0;
      pc_rst   <= 1'b1;
      pc_write <= 1'b0;
      pc_sel   <= 1'b0;
      ir_load  <= 1'b0;
      rf_we    <= 1'b0;
      wb_sel   <= 1'b0;
      stat_en  <= 1'b0;
      mem_rd   <= 1'b0;
      mem_wr   <= 1'b0;
      halted   <= 1'b0;
    end else begin
      state    <= state_nx;
      op_q     <= op_nx;
      mm_q     <= mm_nx;
      wait_cnt <= wait_nx;
      err      <= err_nx;
      pc_rst   <= pc_rst_nx;
      pc_write <= pc_write_nx;
      pc_sel   <= pc_sel_nx;
      ir_load  <= ir_load_nx;
      rf_we    <= rf_we_nx;
      wb_sel   <= wb_sel_nx;
      stat_en  <= stat_en_nx;
      mem_rd   <= mem_rd_nx;
      mem_wr   <= mem_wr_nx;
      halted   <= halted_nx;
    end
  end

endmodule

// File: tb/tb_sisc_seq.sv
// Randomized bench for sisc_seq: per-instruction expected output traces are built
// from the instruction's timing rules and compared cycle by cycle.
module tb_sisc_seq;
  localparam int WAIT_MAX = 15;

  // Output vector bit positions
  localparam int B_RST = 10, B_PCW = 9, B_SEL = 8, B_IRL = 7, B_RFW = 6, B_WBS = 5;
  localparam int B_STE = 4, B_MRD = 3, B_MWR = 2, B_HLT = 1, B_ERR = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] opcode = 4'h0, mm = 4'h0, stat = 4'h0;
  logic mem_ready = 1'b0;
  logic pc_rst, pc_write, pc_sel, ir_load, rf_we, wb_sel, stat_en, mem_rd, mem_wr, halted, err;
  logic [10:0] obs;

  int n_vec = 0;
  int n_err = 0;
  bit err_m = 1'b0;

  sisc_seq #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mm(mm), .stat(stat), .mem_ready(mem_ready),
    .pc_rst(pc_rst), .pc_write(pc_write), .pc_sel(pc_sel), .ir_load(ir_load),
    .rf_we(rf_we), .wb_sel(wb_sel), .stat_en(stat_en), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  assign obs = {pc_rst, pc_write, pc_sel, ir_load, rf_we, wb_sel, stat_en, mem_rd, mem_wr, halted, err};

  task automatic chk(input string tag, input logic [10:0] got, input logic [10:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (rst,pcw,sel,irl,rfw,wbs,ste,mrd,mwr,hlt,err)",
               tag, got, exp);
    end
  endtask

  function automatic logic [10:0] bitv(input int b);
    logic [10:0] v;
    v = 11'd0;
    v[b] = 1'b1;
    return v;
  endfunction

  function automatic logic [10:0] errv();
    return err_m ? bitv(B_ERR) : 11'd0;
  endfunction

  // Reset held 3 cycles: pc_rst alone throughout, then the release cycle leads to FETCH.
  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    err_m = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("reset%0d", i), obs, bitv(B_RST));
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Runs one instruction from its FETCH cycle. k = MEM cycle on which mem_ready is
  // raised (k > WAIT_MAX means never); abort_mem > 0 asserts rst after that MEM cycle.
  task automatic run_instr(input logic [3:0] op, input logic [3:0] m, input logic [3:0] st,
                           input int k, input int abort_mem);
    logic [10:0] q[$];
    int midx[$];
    bit halt_after, legal, is_br, tk;
    int n;
    halt_after = 1'b0;
    legal = (op == 4'h0) || (op == 4'h1) || (op == 4'h2) || (op == 4'h4) ||
            (op == 4'h8) || (op == 4'h9);
    is_br = (op == 4'h2) || (op == 4'h4);
    tk = (m == 4'h0) || ((m & st) != 4'h0);

    q.push_back(bitv(B_IRL) | bitv(B_PCW) | errv()); midx.push_back(0);
    q.push_back(errv()); midx.push_back(0);
    if (op == 4'h1)        q.push_back(bitv(B_STE) | errv());
    else if (is_br && tk)  q.push_back(bitv(B_PCW) | bitv(B_SEL) | errv());
    else                   q.push_back(errv());
    midx.push_back(0);
    if (!legal) err_m = 1'b1;

    if (op == 4'h0 && m == 4'hF) begin
      halt_after = 1'b1;
      for (int i = 0; i < 3; i++) begin q.push_back(bitv(B_HLT) | errv()); midx.push_back(0); end
    end else if (op == 4'h1) begin
      q.push_back(bitv(B_RFW) | errv()); midx.push_back(0);
    end else if (op == 4'h8 || op == 4'h9) begin
      n = (k <= WAIT_MAX) ? k : WAIT_MAX;
      for (int i = 1; i <= n; i++) begin
        q.push_back(bitv(op == 4'h8 ? B_MRD : B_MWR) | errv());
        midx.push_back(i);
      end
      if (k <= WAIT_MAX) begin
        if (op == 4'h8) begin q.push_back(bitv(B_RFW) | bitv(B_WBS) | errv()); midx.push_back(0); end
      end else begin
        err_m = 1'b1;
        halt_after = 1'b1;
        for (int i = 0; i < 3; i++) begin q.push_back(bitv(B_HLT) | errv()); midx.push_back(0); end
      end
    end

    opcode = op; mm = m; stat = st;
    for (int c = 0; c < q.size(); c++) begin
      if (midx[c] != 0) mem_ready = (midx[c] == k);
      else              mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk($sformatf("op%h_mm%h_st%h_c%0d", op, m, st, c), obs, q[c]);
      if (abort_mem != 0 && midx[c] == abort_mem) begin
        do_reset();
        return;
      end
      @(posedge clk); #1;
    end
    if (halt_after) do_reset();
  endtask

  initial begin
    logic [3:0] op, m, st;
    int k, ab, sel;
    do_reset();
    run_instr(4'h1, 4'h3, 4'h5, 0, 0);          // ALU
    run_instr(4'h2, 4'b0001, 4'b0001, 0, 0);    // BRR taken
    run_instr(4'h2, 4'b0001, 4'b0000, 0, 0);    // BRR not taken
    run_instr(4'h4, 4'h0, 4'h0, 0, 0);          // BRA unconditional
    run_instr(4'h8, 4'h0, 4'h0, 3, 0);          // LOD, ready on 3rd MEM cycle
    run_instr(4'h9, 4'h0, 4'h0, 1, 0);          // STR, immediate ready
    run_instr(4'h8, 4'h0, 4'h0, WAIT_MAX, 0);   // ready on last allowed cycle
    run_instr(4'h7, 4'h0, 4'h0, 0, 0);          // illegal -> err, continue
    run_instr(4'h0, 4'h2, 4'h0, 0, 0);          // NOP with sticky err
    run_instr(4'h0, 4'hF, 4'h0, 0, 0);          // HLT
    run_instr(4'h9, 4'h0, 4'h0, 99, 0);         // STR timeout
    run_instr(4'h8, 4'h0, 4'h0, 10, 4);         // reset during MEM
    for (int t = 0; t < 120; t++) begin
      sel = $urandom_range(0, 13);
      case (sel)
        0, 1:    op = 4'h0;
        2, 3:    op = 4'h1;
        4, 5:    op = 4'h2;
        6:       op = 4'h4;
        7, 8:    op = 4'h8;
        9, 10:   op = 4'h9;
        default: op = 4'($urandom_range(0, 15));
      endcase
      m  = 4'($urandom_range(0, 15));
      st = 4'($urandom_range(0, 15));
      if (op == 4'h0 && $urandom_range(0, 3) != 0) m = 4'($urandom_range(0, 14));
      k  = $urandom_range(1, WAIT_MAX + 3);
      ab = 0;
      if ((op == 4'h8 || op == 4'h9) && k > 2 && $urandom_range(0, 5) == 0)
        ab = $urandom_range(1, (k > WAIT_MAX ? WAIT_MAX : k) - 1);
      run_instr(op, m, st, k, ab);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
